// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch stage that owns the PC, reads the instruction
//            ROM into a prefetch FIFO and hands words to execute via
//            valid/ready. Optional macro FETCH_PERF_EN adds stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int              DEPTH   = 4,
   parameter int              AW      = 8,
   parameter int              IW      = 9,
   parameter logic [IW-1:0]   HALT_OP = 9'h1FF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [AW-1:0]     imem_addr,
   input  logic [IW-1:0]     imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IW-1:0]     out_instr,
   output logic [AW-1:0]     out_pc,
   input  logic              redirect,
   input  logic              redirect_rel,
   input  logic [AW-1:0]     redirect_off,
   output logic              halt
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int            PW        = $clog2(DEPTH);
   localparam logic [PW:0]   C_PTR_ONE = (PW+1)'(1);
   localparam logic [AW-1:0] C_PC_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [AW-1:0]    r_fetch_pc;
   logic [AW-1:0]    r_last_pc;
   logic [PW:0]      r_wr_ptr;
   logic [PW:0]      r_rd_ptr;
   logic [IW-1:0]    r_mem_instr [DEPTH];
   logic [AW-1:0]    r_mem_pc    [DEPTH];

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_redirect_act;
   logic             w_flush;
   logic [AW-1:0]    w_base;
   logic [AW-1:0]    w_target;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

   assign out_valid = !w_empty;
   assign out_instr = r_mem_instr[r_rd_ptr[PW-1:0]];
   assign out_pc    = r_mem_pc[r_rd_ptr[PW-1:0]];
   assign imem_addr = r_fetch_pc;
   assign halt      = (r_state == S_HALTED) && w_empty;

   assign w_pop          = out_valid && out_ready;
   assign w_redirect_act = redirect && !start && (r_state != S_IDLE);
   assign w_flush        = start || w_redirect_act;
   assign w_push         = (r_state == S_RUN) && !w_flush && (!w_full || w_pop);

   // A pop in the redirect cycle retires first, so its PC is the relative base
   assign w_base   = w_pop ? out_pc : r_last_pc;
   assign w_target = redirect_rel ? (w_base + redirect_off) : redirect_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (start) begin
         w_next_state = S_IDLE;
      end else if (r_state == S_IDLE) begin
         w_next_state = S_RUN;
      end else if (w_redirect_act) begin
         w_next_state = S_RUN;
      end else if (w_push && (imem_data == HALT_OP)) begin
         w_next_state = S_HALTED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= '0;
         r_last_pc  <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_pop) begin
            r_last_pc <= out_pc;
         end
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
         end
         if (start) begin
            r_fetch_pc <= '0;
         end else if (w_redirect_act) begin
            r_fetch_pc <= w_target;
         end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + C_PC_ONE;
         end
      end
   end

   // Entries reset to zero so the head outputs are defined even when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_instr[i] <= '0;
            r_mem_pc[i]    <= '0;
         end
      end else if (w_push) begin
         r_mem_instr[r_wr_ptr[PW-1:0]] <= imem_data;
         r_mem_pc[r_wr_ptr[PW-1:0]]    <= r_fetch_pc;
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (start) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_RUN) && !out_valid && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [7:0]    imem_addr;
   logic [8:0]    imem_data;
   logic          out_valid;
   logic          out_ready;
   logic [8:0]    out_instr;
   logic [7:0]    out_pc;
   logic          redirect;
   logic          redirect_rel;
   logic [7:0]    redirect_off;
   logic          halt;
`ifdef FETCH_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   logic [8:0]    rom [256];
   int            n_tests;
   int            n_fail;

   fetch_queue #(
      .DEPTH   (4),
      .AW      (8),
      .IW      (9),
      .HALT_OP (9'h1FF)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .redirect     (redirect),
      .redirect_rel (redirect_rel),
      .redirect_off (redirect_off),
      .halt         (halt)
`ifdef FETCH_PERF_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   assign imem_data = rom[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      start        = 1'b1;
      out_ready    = 1'b1;
      redirect     = 1'b0;
      redirect_rel = 1'b0;
      redirect_off = 8'h00;
      for (int i = 0; i < 256; i++) rom[i] = 9'(i);

      #12;
      chk("rst_addr",  32'(imem_addr), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_instr", 32'(out_instr), 32'h0);
      chk("rst_pc",    32'(out_pc),    32'h0);
      chk("rst_halt",  32'(halt),      32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_stall", 32'(stall_cnt), 32'h0);
`endif
      rst_n = 1'b1;
      tick();
      start = 1'b0;

      // Start latency and full-rate streaming
      tick();
      chk("start_gap", 32'(out_valid), 32'h0);
      tick();
      for (int k = 0; k < 6; k++) begin
         chk("stream_valid", 32'(out_valid), 32'h1);
         chk("stream_pc",    32'(out_pc),    32'(k));
         chk("stream_instr", 32'(out_instr), 32'(k));
         tick();
      end

      // Back-pressure: FIFO fills to DEPTH and holds
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 11; k++) tick();
      chk("bp_addr",  32'(imem_addr), 32'h4);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_pc",    32'(out_pc),    32'h0);
      out_ready = 1'b1;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("bp_drain_pc", 32'(out_pc), 32'(k));
      end

      // Relative redirect in the same cycle as popping pc 0x10
      for (int k = 0; k < 20 && out_pc != 8'h10; k++) tick();
      chk("find_10", 32'(out_pc), 32'h10);
      redirect     = 1'b1;
      redirect_rel = 1'b1;
      redirect_off = 8'hFC;
      tick();
      redirect = 1'b0;
      chk("rel_bubble", 32'(out_valid), 32'h0);
      tick();
      chk("rel_valid", 32'(out_valid), 32'h1);
      chk("rel_pc",    32'(out_pc),    32'h0C);
      chk("rel_instr", 32'(out_instr), 32'h0C);

      // Absolute redirect
      redirect     = 1'b1;
      redirect_rel = 1'b0;
      redirect_off = 8'h80;
      tick();
      redirect = 1'b0;
      chk("abs_bubble", 32'(out_valid), 32'h0);
      tick();
      chk("abs_pc", 32'(out_pc), 32'h80);

      // Halt at pc 5
      rom[5] = 9'h1FF;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         chk("halt_seq_pc", 32'(out_pc), 32'(k));
         chk("halt_early",  32'(halt),   32'h0);
         tick();
      end
      chk("halt_set",   32'(halt),      32'h1);
      chk("halt_empty", 32'(out_valid), 32'h0);
      chk("halt_addr",  32'(imem_addr), 32'h6);
      tick();
      chk("halt_hold",  32'(halt),      32'h1);
      redirect     = 1'b1;
      redirect_rel = 1'b0;
      redirect_off = 8'h20;
      tick();
      redirect = 1'b0;
      chk("halt_clr", 32'(halt), 32'h0);
      tick();
      chk("resume_pc", 32'(out_pc), 32'h20);
      tick();
      chk("resume_next", 32'(out_pc), 32'h21);

      // PC wraps mod 256
      redirect     = 1'b1;
      redirect_off = 8'hFE;
      tick();
      redirect = 1'b0;
      tick();
      chk("wrap_pc0", 32'(out_pc), 32'hFE);
      tick();
      chk("wrap_pc1", 32'(out_pc), 32'hFF);
      tick();
      chk("wrap_pc2", 32'(out_pc), 32'h00);
      tick();
      chk("wrap_pc3", 32'(out_pc), 32'h01);

      // Asynchronous reset mid-stream
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_addr",  32'(imem_addr), 32'h0);
      chk("arst_pc",    32'(out_pc),    32'h0);

`ifdef FETCH_PERF_EN
      start = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      chk("perf_clr", 32'(stall_cnt), 32'h0);
      start = 1'b0;
      tick();
      tick();
      chk("perf_first", 32'(stall_cnt), 32'h1);
      tick();
      redirect     = 1'b1;
      redirect_rel = 1'b0;
      redirect_off = 8'h40;
      tick();
      redirect = 1'b0;
      tick();
      chk("perf_bubble", 32'(stall_cnt), 32'h2);
      start = 1'b1;
      tick();
      chk("perf_start", 32'(stall_cnt), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
